// File: rtl/tx_fifo_wr_ctrl.sv
// PCS TX async FIFO write-side controller.
// Binary/Gray write pointer, full/level flags, drain and overflow tracking.
module tx_fifo_wr_ctrl #(
  parameter int ADDRSIZE     = 7,
  parameter int AFULL_THRESH = 120
) (
  input  logic                wclk,
  input  logic                wrst_n,
  input  logic                winc,
  input  logic [ADDRSIZE:0]   wq2_rptr,
  input  logic                drain_req,
  input  logic                clr_ovf,
  output logic                wen,
  output logic [ADDRSIZE-1:0] waddr,
  output logic [ADDRSIZE:0]   wptr,
  output logic                wfull,
  output logic                walmost_full,
  output logic [ADDRSIZE:0]   wlevel,
  output logic                drain_done,
  output logic [7:0]          ovf_cnt,
  output logic                ovf_sticky
);

  typedef enum logic [1:0] {
    INIT  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t state;
  state_t state_nxt;
  logic   init_cnt;
  logic   done_nxt;
  logic   ovf_ev;

  logic [ADDRSIZE:0] wbin;
  logic [ADDRSIZE:0] wbin_nxt;
  logic [ADDRSIZE:0] gray_nxt;
  logic [ADDRSIZE:0] rbin;
  logic [ADDRSIZE:0] level_nxt;
  logic [ADDRSIZE:0] full_cmp;

  always_ff @(posedge wclk or negedge wrst_n) begin
    if (!wrst_n) begin
      state    <= INIT;
      init_cnt <= 1'b0;
    end else begin
      state    <= state_nxt;
      init_cnt <= (state == INIT) ? ~init_cnt : 1'b0;
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      INIT:    if (init_cnt) state_nxt = RUN;
      RUN:     if (drain_req) state_nxt = DRAIN;
      DRAIN:   if (wlevel == '0) state_nxt = RUN;
      default: state_nxt = INIT;
    endcase
  end

  always_comb begin
    wen      = (state == RUN) & winc & ~wfull;
    done_nxt = (state == DRAIN) & (wlevel == '0);
  end

  // Gray-to-binary: each bit is the XOR of all Gray bits at or above it
  always_comb begin
    rbin = '0;
    for (int i = 0; i <= ADDRSIZE; i++) begin
      rbin[i] = ^(wq2_rptr >> i);
    end
  end

  assign wbin_nxt  = wbin + (ADDRSIZE+1)'(wen);
  assign gray_nxt  = wbin_nxt ^ (wbin_nxt >> 1);
  assign level_nxt = wbin_nxt - rbin;
  assign full_cmp  = {~wq2_rptr[ADDRSIZE:ADDRSIZE-1],
                      wq2_rptr[ADDRSIZE-2:0]};
  assign waddr     = wbin[ADDRSIZE-1:0];
  assign ovf_ev    = winc & ~wen;

  always_ff @(posedge wclk or negedge wrst_n) begin
    if (!wrst_n) begin
      wbin         <= '0;
      wptr         <= '0;
      wfull        <= 1'b0;
      walmost_full <= 1'b0;
      wlevel       <= '0;
      drain_done   <= 1'b0;
    end else begin
      wbin         <= wbin_nxt;
      wptr         <= gray_nxt;
      wfull        <= (gray_nxt == full_cmp);
      walmost_full <= (level_nxt >= (ADDRSIZE+1)'(AFULL_THRESH));
      wlevel       <= level_nxt;
      drain_done   <= done_nxt;
    end
  end

  // A dropped write in the clearing cycle survives the clear
  always_ff @(posedge wclk or negedge wrst_n) begin
    if (!wrst_n) begin
      ovf_cnt    <= 8'd0;
      ovf_sticky <= 1'b0;
    end else if (clr_ovf) begin
      ovf_cnt    <= ovf_ev ? 8'd1 : 8'd0;
      ovf_sticky <= ovf_ev;
    end else if (ovf_ev) begin
      ovf_sticky <= 1'b1;
      if (ovf_cnt != 8'hFF) ovf_cnt <= ovf_cnt + 8'd1;
    end
  end

endmodule

// File: doc/tx_fifo_wr_ctrl.md
Name: tx_fifo_wr_ctrl

Overview:
Write-side controller for the PCS TX asynchronous FIFO, in the write clock domain. It sequences writes from the encoder into the dual-port RAM and generates the binary RAM address and the Gray-coded write pointer for the read domain. It derives full, almost-full and fill level from the double-flop-synchronised Gray read pointer. It also provides drain sequencing and overflow accounting.

Parameters:
ADDRSIZE, 7, RAM address width; FIFO depth = 2**ADDRSIZE (128)
AFULL_THRESH, 120, fill level at or above which walmost_full asserts

Ports:
wclk  input  1  write-domain clock
wrst_n  input  1  asynchronous active-low reset
winc  input  1  write request from the encoder, one word per cycle
wq2_rptr  input  ADDRSIZE+1  Gray read pointer after the 2-flop synchroniser
drain_req  input  1  one-cycle pulse: stop accepting writes until the FIFO is empty
clr_ovf  input  1  one-cycle pulse: clear the overflow counter and sticky flag
wen  output  1  RAM write enable (combinational)
waddr  output  ADDRSIZE  RAM write address = wbin[ADDRSIZE-1:0]
wptr  output  ADDRSIZE+1  registered Gray write pointer to the read-domain synchroniser
wfull  output  1  FIFO full, registered
walmost_full  output  1  level >= AFULL_THRESH, registered
wlevel  output  ADDRSIZE+1  registered fill level, 0..2**ADDRSIZE
drain_done  output  1  one-cycle pulse when the drain completes
ovf_cnt  output  8  saturating count of dropped writes
ovf_sticky  output  1  set on any dropped write

Behaviour:
- Reset (async assert, sync release): wbin=0, wptr=0, wfull=0, walmost_full=0, wlevel=0, ovf_cnt=0, ovf_sticky=0, drain_done=0, state=INIT, init counter=0.
- Gray conversion: gray = (bin>>1)^bin.
- Read pointer decode: rbin is decoded from wq2_rptr combinationally by an XOR prefix from the MSB.
- State machine:
  - INIT: counts 2 wclk cycles so the synchroniser flushes its reset values, then goes to RUN. wen=0.
  - RUN: wen = winc & ~wfull. If drain_req, go to DRAIN; wen is still evaluated normally in that cycle.
  - DRAIN: wen=0. When the registered wlevel==0, pulse drain_done for 1 cycle and return to RUN.
  - drain_req outside RUN is ignored.
- Pointer update: wbin_next = wbin + wen, modulo 2**(ADDRSIZE+1). wptr <= gray(wbin_next). waddr is driven from the current wbin, so the write in cycle N lands at the address held in cycle N.
- Full: wfull <= (gray(wbin_next) == {~wq2_rptr[ADDRSIZE:ADDRSIZE-1], wq2_rptr[ADDRSIZE-2:0]}). It asserts in the cycle after the write that fills the FIFO. No write is ever issued while wfull=1.
- Level: wlevel <= (wbin_next - rbin) modulo 2**(ADDRSIZE+1). It is pessimistic, overstating the true level by up to the synchroniser latency. It never exceeds 2**ADDRSIZE.
- Almost full: walmost_full <= (level_next >= AFULL_THRESH), updated in the same cycle as wlevel.
- Overflow event: winc=1 with wen=0. This covers wfull in RUN and any winc during INIT or DRAIN.
  - On an overflow event: ovf_cnt increments, saturating at 255, and ovf_sticky <= 1.
  - clr_ovf with no event in the same cycle: ovf_cnt=0, ovf_sticky=0.
  - clr_ovf and an event in the same cycle: ovf_cnt=1, ovf_sticky=1.
- Wrap: the pointer MSB toggles every 2**ADDRSIZE writes. Full/empty distinction relies on the MSB, and waddr wraps 127 -> 0 without any gap.
- Simultaneous write and read-pointer advance: the level uses the new values of both sides. If full is reached and a read frees a slot in the same cycle, wfull reflects the post-update compare.
- Reset mid-operation: everything returns to the reset values immediately, including an in-progress DRAIN. The controller re-enters INIT.

Test Plan:
1. Reset then release with winc=1 and wq2_rptr=0 -> wen=0 for 2 cycles with ovf_cnt=2, then wen=1 with waddr 0,1,2 and wptr 1,3,2.
2. Hold wq2_rptr=0 and write 128 words -> walmost_full rises the cycle after write 120, wfull and wlevel=128 the cycle after write 128, and a further winc increments ovf_cnt with wen=0.
3. Continuous writes with the read pointer tracking 4 behind, for 300 writes -> waddr wraps 127->0, the wptr MSB toggles at 128 and 256, and wfull never asserts.
4. Fill to level 10, pulse drain_req, then advance wq2_rptr to Gray(10) -> winc is dropped, and drain_done pulses once the cycle after wlevel reads 0, then RUN resumes.
5. Force 300 overflows -> ovf_cnt saturates at 255. clr_ovf together with an overflow -> ovf_cnt=1 and ovf_sticky=1. clr_ovf alone -> both 0.
6. Assert wrst_n=0 mid-DRAIN at level 50 -> all outputs are 0 asynchronously, and after release the INIT 2-cycle hold repeats.
